// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: multi-operand accumulator controller.
// A single 3:2 carry-save slice folds a programmed number of operands into
// redundant sum/carry registers. One carry-propagate add then resolves the
// total, which is offered on a valid/ready result port.
module csa_accum_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 4,
    parameter int ACC_W = WIDTH + CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_op_count,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [ACC_W-1:0] o_out_sum,
    input  logic             i_out_ready,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Sum output of the 3:2 compressor (bitwise full-adder sum).
    function automatic logic [ACC_W-1:0] csa_sum(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] c
    );
        return a ^ b ^ c;
    endfunction

    // Carry output of the 3:2 compressor, already shifted into its weight.
    // The bit shifted out of the top is dropped; ACC_W is sized so a legal
    // job never needs it.
    function automatic logic [ACC_W-1:0] csa_carry(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] c
    );
        logic [ACC_W-1:0] maj;
        maj = (a & b) | (b & c) | (c & a);
        return {maj[ACC_W-2:0], 1'b0};
    endfunction

    state_t           r_state;
    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_c;
    logic [CNT_W-1:0] r_rem;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [ACC_W-1:0] w_s_nxt;
    logic [ACC_W-1:0] w_c_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [ACC_W-1:0] w_out_sum_nxt;
    logic [ACC_W-1:0] w_x;
    logic             w_accept;

    assign w_x      = {{(ACC_W-WIDTH){1'b0}}, i_in_data};
    assign w_accept = i_in_valid && r_in_ready;

    // Next-state and datapath update for the job scheduler.
    always_comb begin
        w_state_nxt   = r_state;
        w_s_nxt       = r_s;
        w_c_nxt       = r_c;
        w_rem_nxt     = r_rem;
        w_out_sum_nxt = r_out_sum;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_op_count != CNT_ZERO) begin
                        w_s_nxt     = ACC_ZERO;
                        w_c_nxt     = ACC_ZERO;
                        w_rem_nxt   = i_op_count;
                        w_state_nxt = ST_ACCUM;
                    end else begin
                        // Empty job: the total is trivially zero.
                        w_out_sum_nxt = ACC_ZERO;
                        w_state_nxt   = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_s_nxt   = csa_sum(r_s, r_c, w_x);
                    w_c_nxt   = csa_carry(r_s, r_c, w_x);
                    w_rem_nxt = r_rem - CNT_ONE;
                    if (r_rem == CNT_ONE) begin
                        w_state_nxt = ST_RESOLVE;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                // The only carry-propagate add of the whole job.
                w_out_sum_nxt = r_s + r_c;
                w_state_nxt   = ST_DONE;
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; handshake flags are decoded from
    // the next state so they come straight out of flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_s         <= ACC_ZERO;
            r_c         <= ACC_ZERO;
            r_rem       <= CNT_ZERO;
            r_out_sum   <= ACC_ZERO;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_c         <= w_c_nxt;
            r_rem       <= w_rem_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_in_ready  <= (w_state_nxt == ST_ACCUM);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: expected totals are computed by the
// bench when operands are driven, queued, and compared when a result appears.
module tb_csa_accum_ctrl;

    localparam int WIDTH = 5;
    localparam int CNT_W = 4;
    localparam int ACC_W = WIDTH + CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_op_count;
    logic             i_in_valid;
    logic [WIDTH-1:0] i_in_data;
    logic             o_in_ready;
    logic             o_out_valid;
    logic [ACC_W-1:0] o_out_sum;
    logic             i_out_ready;
    logic             o_busy;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [ACC_W-1:0] sb_q[$];
    int               acc;

    csa_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (i_start),
        .i_op_count  (i_op_count),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_sum   (o_out_sum),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(o_in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
        chk({tag, "_out_sum"},   32'(o_out_sum),   32'd0);
        chk({tag, "_busy"},      32'(o_busy),      32'd0);
    endtask

    task automatic start_job(input int cnt);
        i_start    = 1'b1;
        i_op_count = CNT_W'(cnt);
        acc        = 0;
        tick();
        i_start    = 1'b0;
        i_op_count = '0;
    endtask

    task automatic send(input string tag, input int x);
        chk({tag, "_in_ready"}, 32'(o_in_ready), 32'd1);
        i_in_valid = 1'b1;
        i_in_data  = WIDTH'(x);
        acc        = acc + x;
        tick();
        i_in_valid = 1'b0;
        i_in_data  = '0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (o_out_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_valid_timeout"}, 32'(o_out_valid), 32'd1);
    endtask

    task automatic finish_job(input string tag);
        logic [ACC_W-1:0] exp;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_sum"}, 32'(o_out_sum), 32'(exp));
        end
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(o_out_valid), 32'd0);
        chk({tag, "_idle"},       32'(o_busy),      32'd0);
    endtask

    initial begin
        logic [ACC_W-1:0] held;
        rst = 1'b1; i_start = 1'b0; i_op_count = '0; i_in_valid = 1'b0;
        i_in_data = '0; i_out_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Job 1: 5 + 9 + 31, result two cycles after the last accept.
        start_job(3);
        chk("j1_busy", 32'(o_busy), 32'd1);
        send("j1_a", 5);
        send("j1_b", 9);
        send("j1_c", 31);
        sb_q.push_back(ACC_W'(acc));
        chk("j1_resolve_valid", 32'(o_out_valid), 32'd0);
        chk("j1_resolve_ready", 32'(o_in_ready),  32'd0);
        tick();
        chk("j1_valid_k2", 32'(o_out_valid), 32'd1);
        finish_job("j1");

        // Job 2: fifteen maximal operands, largest legal total.
        start_job(15);
        for (int i = 0; i < 15; i++) send("j2_op", 31);
        sb_q.push_back(ACC_W'(acc));
        chk("j2_expect_465", 32'(acc), 32'd465);
        wait_valid("j2", 5);
        finish_job("j2");

        // Job 3: single operand after three idle input cycles.
        start_job(1);
        for (int i = 0; i < 3; i++) begin
            chk("j3_gap_ready", 32'(o_in_ready), 32'd1);
            tick();
        end
        send("j3_op", 7);
        sb_q.push_back(ACC_W'(acc));
        wait_valid("j3", 5);
        finish_job("j3");

        // Job 4: empty job goes straight to DONE and consumes nothing.
        i_in_valid = 1'b1;
        i_in_data  = WIDTH'(13);
        start_job(0);
        sb_q.push_back(ACC_W'(0));
        chk("j4_valid",    32'(o_out_valid), 32'd1);
        chk("j4_no_ready", 32'(o_in_ready),  32'd0);
        chk("j4_sum_now",  32'(o_out_sum),   32'd0);
        i_in_valid = 1'b0;
        i_in_data  = '0;
        finish_job("j4");

        // Job 5: stall in DONE while start pulses; result must hold.
        start_job(2);
        send("j5_a", 10);
        send("j5_b", 20);
        sb_q.push_back(ACC_W'(acc));
        wait_valid("j5", 5);
        held = o_out_sum;
        for (int i = 0; i < 5; i++) begin
            i_start    = (i % 2 == 0);
            i_op_count = CNT_W'(5);
            tick();
            chk("j5_stall_valid", 32'(o_out_valid), 32'd1);
            chk("j5_stall_sum",   32'(o_out_sum),   32'(held));
            chk("j5_stall_ready", 32'(o_in_ready),  32'd0);
        end
        i_start    = 1'b0;
        i_op_count = '0;
        finish_job("j5");
        tick();
        chk("j5_start_ignored", 32'(o_busy), 32'd0);

        // Job 6: reset after two of four operands, then a fresh job.
        start_job(4);
        send("j6_a", 3);
        send("j6_b", 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("abort");
        start_job(2);
        send("j7_a", 1);
        send("j7_b", 2);
        sb_q.push_back(ACC_W'(acc));
        wait_valid("j7", 5);
        finish_job("j7");

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_accum_ctrl.md
# csa_accum_ctrl

Sequential multi-operand accumulator controller built around a 3:2 carry-save stage. It accepts a programmed number of WIDTH-bit operands over a valid/ready stream and folds each one into redundant sum/carry registers with no carry propagation. It then performs a single carry-propagate resolve and presents the total on a valid/ready result port. It is the scheduler that lets one carry-save slice serve an arbitrary-length operand sequence instead of a fixed three-input tree.

## Interface
- WIDTH, 5: operand width in bits.
- CNT_W, 4: operand-count width. Up to 2^CNT_W−1 operands per job.
- ACC_W, WIDTH+CNT_W: accumulator and result width. Overflow-free for any legal job.

- clk  in  1  rising-edge clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job. Sampled only in IDLE.
- op_count  in  CNT_W  number of operands in the job. Sampled with start.
- in_valid  in  1  operand present.
- in_data  in  WIDTH  operand, unsigned.
- in_ready  out  1  block accepts an operand this cycle.
- out_valid  out  1  result available.
- out_sum  out  ACC_W  result, unsigned.
- out_ready  in  1  consumer takes the result.
- busy  out  1  high in every state except IDLE.

## Operation
- Internal registers: S[ACC_W-1:0] (partial sum), C[ACC_W-1:0] (carry, stored pre-shifted), rem[CNT_W-1:0] (operands remaining).
- FSM states: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - start=1, op_count≠0: S=0, C=0, rem=op_count, go to ACCUM.
  - start=1, op_count=0: out_sum=0, go directly to DONE.
  - start=0: stay in IDLE.
- ACCUM:
  - in_ready=1. An operand is accepted on a cycle with in_valid & in_ready.
  - Operand x is zero-extended to ACC_W bits.
  - S ← S ^ C ^ x.
  - C ← ((S&C)|(C&x)|(x&S)) << 1, truncated to ACC_W bits.
  - rem ← rem−1.
  - Accepting the operand with rem=1 moves the FSM to RESOLVE.
  - Cycles with in_valid=0 change nothing.
- RESOLVE: one cycle. out_sum ← S + C (ACC_W bits, modulo 2^ACC_W). Go to DONE.
- DONE:
  - out_valid=1. out_sum is held stable.
  - On out_ready=1, go to IDLE. out_valid drops in the next cycle.
- start is ignored outside IDLE.
- in_data is ignored outside ACCUM. in_ready=0 outside ACCUM.
- Invariant: after k accepted operands, S+C equals their exact sum.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sum=0, busy=0. FSM=IDLE, S=C=rem=0.
- Reset takes precedence over every other input in any state. A reset mid-job discards all partial state. No result is emitted for the aborted job.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from any input to these outputs.
- Start to first accept: start high at edge t. in_ready is high from cycle t+1.
- Last operand to result: last operand accepted at edge k. RESOLVE occupies cycle k+1. out_valid is high from cycle k+2.
- Throughput:
  - One operand per cycle when in_valid is held high.
  - Minimum job length is N+3 cycles for N operands: start, N accepts, RESOLVE, handshake.
  - op_count=0 takes 2 cycles.
- Back-to-back jobs: start may be asserted in the first IDLE cycle after the result handshake.
- out_valid and out_sum remain stable for as long as out_ready stays low.

## Test plan
- op_count=3, operands 5, 9, 31 on consecutive cycles -> out_sum=45 (0x02D). out_valid rises 2 cycles after the third accept.
- op_count=15, all operands 31 -> out_sum=465. No overflow at ACC_W=9.
- op_count=1, operand 7 with in_valid gaps of 3 cycles before it -> out_sum=7. in_ready stays high during the gaps.
- op_count=0 -> DONE with out_sum=0 on the next cycle. No operands are consumed.
- Hold out_ready low 5 cycles in DONE and pulse start during that time -> out_sum stays stable. start is ignored. The result handshake completes, then the FSM returns to IDLE.
- Assert rst after 2 of 4 operands are accepted -> all outputs return to their reset values next cycle. A fresh job (op_count=2, operands 1, 2) then yields out_sum=3.
